mct_axi_mem_responder: RTL and testbench

- AXI4 memory responder (slave) for the reduced m00_axi interface driven by the kernel top's read channel and write master: answers AR/R bursts and AW/W/B bursts from an on-chip byte-enabled memory.
- Used as the memory-side model in kernel-level benches and as a standalone on-chip buffer when DDR is not attached.
- Read and write paths are independent and concurrent.

---
 rtl/mct_axi_mem_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_mct_axi_mem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mct_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// mct_axi_mem_responder
//   AXI4 memory-side responder for the reduced m00_axi interface. Serves AR/R
//   bursts and AW/W/B bursts from an on-chip byte-enabled memory. The read and
//   write paths are independent and run concurrently.
//
// Ports
//   ap_clk, rst_n          clock, synchronous active-low reset
//   s_axi_aw*/w*/b*        write address, data and response channels
//   s_axi_ar*/r*           read address and data channels
//   err_wlast              sticky flag: wlast disagreed with the awlen beat count
//   rd_burst_cnt           completed read bursts (last R handshake), wraps at 2^32
//   wr_burst_cnt           completed write bursts (B handshake), wraps at 2^32
//
// Beat index = addr[log2(bytes per beat) +: C_MEM_DEPTH_LOG2]; low byte-offset
// bits and high address bits are ignored, and the index wraps within the memory.
// Every output is a register so that all of them read 0 while rst_n is low.
// -----------------------------------------------------------------------------
module mct_axi_mem_responder #(
  parameter int C_ADDR_WIDTH     = 64,
  parameter int C_DATA_WIDTH     = 512,
  parameter int C_MEM_DEPTH_LOG2 = 10
) (
  input  logic                      ap_clk,
  input  logic                      rst_n,
  // write address channel
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  // write data channel
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  // write response channel
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  // read address channel
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  // read data channel
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                      s_axi_rlast,
  // status
  output logic                      err_wlast,
  output logic [31:0]               rd_burst_cnt,
  output logic [31:0]               wr_burst_cnt
);

  localparam int BYTES  = C_DATA_WIDTH / 8;
  localparam int OFFS_W = $clog2(BYTES);
  localparam int DEPTH  = 1 << C_MEM_DEPTH_LOG2;

  typedef logic [C_MEM_DEPTH_LOG2-1:0] idx_t;
  localparam idx_t IDX_ONE = idx_t'(1);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  logic [C_DATA_WIDTH-1:0] mem_r [DEPTH];

  // read path
  r_state_t   r_state_r, r_state_s;
  idx_t       r_idx_r, r_idx_s;
  logic [8:0] r_rem_r, r_rem_s;
  logic       rd_en_s;
  idx_t       rd_addr_s;
  logic       rd_done_s;
  logic       ar_hs_s, r_hs_s;

  // write path
  w_state_t   w_state_r, w_state_s;
  idx_t       w_idx_r, w_idx_s;
  logic [8:0] w_rem_r, w_rem_s;
  logic       wr_en_s;
  logic       wr_done_s;
  logic       err_set_s;
  logic       aw_hs_s, w_hs_s, b_hs_s;

  // Address bits outside the beat index are intentionally ignored.
  logic unused_addr_s;
  assign unused_addr_s = ^{s_axi_awaddr, s_axi_araddr};

  // Read FSM next state; the next beat's memory read is issued on the same
  // cycle as the current beat's handshake so bursts stream at one beat/cycle.
  always_comb begin
    r_state_s = r_state_r;
    r_idx_s   = r_idx_r;
    r_rem_s   = r_rem_r;
    rd_en_s   = 1'b0;
    rd_addr_s = r_idx_r;
    rd_done_s = 1'b0;
    ar_hs_s   = s_axi_arvalid & s_axi_arready;
    r_hs_s    = s_axi_rvalid & s_axi_rready;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_idx_s   = s_axi_araddr[OFFS_W +: C_MEM_DEPTH_LOG2];
          r_rem_s   = {1'b0, s_axi_arlen} + 9'd1;
          r_state_s = R_FETCH;
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_FETCH: begin
        rd_en_s   = 1'b1;
        rd_addr_s = r_idx_r;
        r_state_s = R_DATA;
      end
      R_DATA: begin
        if (r_hs_s) begin
          if (r_rem_r == 9'd1) begin
            rd_done_s = 1'b1;
            r_state_s = R_IDLE;
          end else begin
            r_idx_s   = r_idx_r + IDX_ONE;
            r_rem_s   = r_rem_r - 9'd1;
            rd_en_s   = 1'b1;
            rd_addr_s = r_idx_r + IDX_ONE;
          end
        end else begin
          r_state_s = R_DATA;
        end
      end
      default: begin
        r_state_s = R_IDLE;
      end
    endcase
  end

  // Read state, registered read-channel outputs and the read burst counter.
  // rdata only reloads on a fetch, so it holds steady while rready is low.
  always_ff @(posedge ap_clk) begin
    if (!rst_n) begin
      r_state_r     <= R_IDLE;
      r_idx_r       <= '0;
      r_rem_r       <= 9'd0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      rd_burst_cnt  <= 32'd0;
    end else begin
      r_state_r     <= r_state_s;
      r_idx_r       <= r_idx_s;
      r_rem_r       <= r_rem_s;
      s_axi_arready <= (r_state_s == R_IDLE);
      s_axi_rvalid  <= (r_state_s == R_DATA);
      s_axi_rlast   <= (r_state_s == R_DATA) && (r_rem_s == 9'd1);
      if (rd_en_s) begin
        s_axi_rdata <= mem_r[rd_addr_s];
      end
      if (rd_done_s) begin
        rd_burst_cnt <= rd_burst_cnt + 32'd1;
      end
    end
  end

  // Write FSM next state; the awlen beat count decides when the burst ends,
  // wlast is only compared against it.
  always_comb begin
    w_state_s = w_state_r;
    w_idx_s   = w_idx_r;
    w_rem_s   = w_rem_r;
    wr_en_s   = 1'b0;
    wr_done_s = 1'b0;
    err_set_s = 1'b0;
    aw_hs_s   = s_axi_awvalid & s_axi_awready;
    w_hs_s    = s_axi_wvalid & s_axi_wready;
    b_hs_s    = s_axi_bvalid & s_axi_bready;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_idx_s   = s_axi_awaddr[OFFS_W +: C_MEM_DEPTH_LOG2];
          w_rem_s   = {1'b0, s_axi_awlen} + 9'd1;
          w_state_s = W_DATA;
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_hs_s) begin
          wr_en_s   = 1'b1;
          err_set_s = (s_axi_wlast != (w_rem_r == 9'd1));
          if (w_rem_r == 9'd1) begin
            w_state_s = W_RESP;
          end else begin
            w_idx_s = w_idx_r + IDX_ONE;
            w_rem_s = w_rem_r - 9'd1;
          end
        end else begin
          w_state_s = W_DATA;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          wr_done_s = 1'b1;
          w_state_s = W_IDLE;
        end else begin
          w_state_s = W_RESP;
        end
      end
      default: begin
        w_state_s = W_IDLE;
      end
    endcase
  end

  // Write state, registered write-channel outputs, sticky error and counter.
  always_ff @(posedge ap_clk) begin
    if (!rst_n) begin
      w_state_r     <= W_IDLE;
      w_idx_r       <= '0;
      w_rem_r       <= 9'd0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      err_wlast     <= 1'b0;
      wr_burst_cnt  <= 32'd0;
    end else begin
      w_state_r     <= w_state_s;
      w_idx_r       <= w_idx_s;
      w_rem_r       <= w_rem_s;
      s_axi_awready <= (w_state_s == W_IDLE);
      s_axi_wready  <= (w_state_s == W_DATA);
      s_axi_bvalid  <= (w_state_s == W_RESP);
      if (err_set_s) begin
        err_wlast <= 1'b1;
      end
      if (wr_done_s) begin
        wr_burst_cnt <= wr_burst_cnt + 32'd1;
      end
    end
  end

  // Byte-enabled memory write port. Contents survive reset. A read issued on
  // the same edge samples the old word (read-first).
  always_ff @(posedge ap_clk) begin
    if (rst_n && wr_en_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) begin
          mem_r[w_idx_r][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mct_axi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mct_axi_mem_responder
//   Directed bench: a table of write-then-read vectors with hand-computed
//   expected beats, followed by sequences for partial strobes, read
//   backpressure, index wrap, wlast errors and reset in the middle of a burst.
//   Inputs change and outputs are sampled on the falling edge of ap_clk.
// -----------------------------------------------------------------------------
module tb_mct_axi_mem_responder;

  logic         ap_clk = 1'b0;
  logic         rst_n  = 1'b0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [63:0]  awaddr = 64'd0;
  logic [7:0]   awlen  = 8'd0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [511:0] wdata  = '0;
  logic [63:0]  wstrb  = 64'd0;
  logic         wlast  = 1'b0;
  logic         bvalid;
  logic         bready = 1'b0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [63:0]  araddr = 64'd0;
  logic [7:0]   arlen  = 8'd0;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [511:0] rdata;
  logic         rlast;
  logic         err_wlast;
  logic [31:0]  rd_burst_cnt;
  logic [31:0]  wr_burst_cnt;

  int checks = 0;
  int errors = 0;
  logic [511:0] rd_buf [256];

  mct_axi_mem_responder dut (
    .ap_clk        (ap_clk),
    .rst_n         (rst_n),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .s_axi_rdata   (rdata),
    .s_axi_rlast   (rlast),
    .err_wlast     (err_wlast),
    .rd_burst_cnt  (rd_burst_cnt),
    .wr_burst_cnt  (wr_burst_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // last_mode: 0 = wlast on final beat only, 1 = also on beat index 1,
  //            2 = wlast never asserted
  task automatic axi_write(input logic [63:0] addr, input int len, input logic [7:0] base,
                           input logic [63:0] strb, input int last_mode);
    int w;
    logic [7:0] bv;
    @(negedge ap_clk);
    awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
    w = 0;
    while (!awready && w < 50) begin @(negedge ap_clk); w++; end
    chk("aw_ready", awready, 1'b1);
    @(negedge ap_clk);
    awvalid = 1'b0;
    chk("w_ready_next_cycle", wready, 1'b1);
    for (int k = 0; k <= len; k++) begin
      bv     = base + 8'(k);
      wvalid = 1'b1;
      wdata  = {64{bv}};
      wstrb  = strb;
      wlast  = (last_mode == 2) ? 1'b0 : ((k == len) || (last_mode == 1 && k == 1));
      w = 0;
      while (!wready && w < 50) begin @(negedge ap_clk); w++; end
      chk("w_ready_beat", wready, 1'b1);
      chk("no_early_b", bvalid, 1'b0);
      @(negedge ap_clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("b_latency", bvalid, 1'b1);
    bready = 1'b1;
    @(negedge ap_clk);
    bready = 1'b0;
    chk("b_single", bvalid, 1'b0);
  endtask

  // bp=1 drives rready as 1,0,0,1,0,0,... ; received beats land in rd_buf
  task automatic axi_read(input logic [63:0] addr, input int len, input bit bp);
    int w, got, cyc;
    logic stall;
    logic [511:0] prev;
    @(negedge ap_clk);
    arvalid = 1'b1; araddr = addr; arlen = 8'(len);
    w = 0;
    while (!arready && w < 50) begin @(negedge ap_clk); w++; end
    chk("ar_ready", arready, 1'b1);
    @(negedge ap_clk);
    arvalid = 1'b0;
    chk("r_latency_t1", rvalid, 1'b0);
    @(negedge ap_clk);
    chk("r_latency_t2", rvalid, 1'b1);
    got = 0; cyc = 0; stall = 1'b0; prev = '0;
    while (got <= len && cyc < 4000) begin
      rready = bp ? (cyc % 3 == 0) : 1'b1;
      if (stall && rvalid) chk("r_stable", rdata, prev);
      if (rvalid && rready) begin
        rd_buf[got] = rdata;
        chk("r_last", rlast, (got == len));
        got++;
      end
      stall = rvalid && !rready;
      prev  = rdata;
      @(negedge ap_clk);
      cyc++;
    end
    rready = 1'b0;
    chk("r_beat_count", got, len + 1);
    chk("r_idle_after", rvalid, 1'b0);
  endtask

  typedef struct {
    logic [63:0] waddr;
    logic [63:0] raddr;
    int          len;
    logic [7:0]  wbase;
    logic [7:0]  rbase;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[5];
  int w, got, cyc;
  logic [7:0] eb;

  initial begin
    vecs[0] = '{64'h0000,                64'h0000, 3, 8'h00, 8'h00, 32'd1};
    vecs[1] = '{64'h0100,                64'h0100, 0, 8'hA5, 8'hA5, 32'd2};
    vecs[2] = '{64'h1000,                64'h1000, 7, 8'h10, 8'h10, 32'd3};
    vecs[3] = '{64'h203F,                64'h2000, 1, 8'h30, 8'h30, 32'd4};
    vecs[4] = '{64'hABCD_0000_0000_0200, 64'h0200, 2, 8'h5A, 8'h5A, 32'd5};

    // reset state
    repeat (3) @(negedge ap_clk);
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_err", err_wlast, 1'b0);
    chk("rst_rd_cnt", rd_burst_cnt, 32'd0);
    chk("rst_wr_cnt", wr_burst_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge ap_clk);
    chk("idle_arready", arready, 1'b1);
    chk("idle_awready", awready, 1'b1);

    // table-driven write/read vectors
    for (int i = 0; i < 5; i++) begin
      axi_write(vecs[i].waddr, vecs[i].len, vecs[i].wbase, {64{1'b1}}, 0);
      axi_read(vecs[i].raddr, vecs[i].len, 1'b0);
      for (int k = 0; k <= vecs[i].len; k++) begin
        eb = vecs[i].rbase + 8'(k);
        chk("vec_rdata", rd_buf[k], {64{eb}});
      end
      chk("vec_wr_cnt", wr_burst_cnt, vecs[i].cnt);
      chk("vec_rd_cnt", rd_burst_cnt, vecs[i].cnt);
    end
    chk("no_err_yet", err_wlast, 1'b0);

    // partial strobe at 0x40
    axi_write(64'h40, 0, 8'hFF, {64{1'b1}}, 0);
    axi_write(64'h40, 0, 8'h00, 64'h1, 0);
    axi_read(64'h40, 0, 1'b0);
    chk("strobe_byte0", rd_buf[0], {{63{8'hFF}}, 8'h00});
    chk("strobe_wr_cnt", wr_burst_cnt, 32'd7);
    chk("strobe_rd_cnt", rd_burst_cnt, 32'd6);

    // 8-beat read under backpressure
    axi_read(64'h1000, 7, 1'b1);
    for (int k = 0; k < 8; k++) begin
      eb = 8'h10 + 8'(k);
      chk("bp_rdata", rd_buf[k], {64{eb}});
    end
    chk("bp_rd_cnt", rd_burst_cnt, 32'd7);

    // index wrap: 0xFFC0 -> index 1023, then 0
    axi_write(64'hFFC0, 1, 8'h70, {64{1'b1}}, 0);
    axi_read(64'h0, 0, 1'b0);
    chk("wrap_idx0", rd_buf[0], {64{8'h71}});
    axi_read(64'hFFC0, 1, 1'b0);
    chk("wrap_rd0", rd_buf[0], {64{8'h70}});
    chk("wrap_rd1", rd_buf[1], {64{8'h71}});

    // early wlast on beat 2 of 4
    axi_write(64'h3000, 3, 8'h40, {64{1'b1}}, 1);
    chk("early_wlast_err", err_wlast, 1'b1);
    chk("early_wlast_wr_cnt", wr_burst_cnt, 32'd9);
    axi_read(64'h3000, 3, 1'b0);
    chk("early_wlast_beat3", rd_buf[3], {64{8'h43}});

    // reset while the third beat of an 8-beat read is presented
    @(negedge ap_clk);
    arvalid = 1'b1; araddr = 64'h1000; arlen = 8'd7;
    w = 0;
    while (!arready && w < 50) begin @(negedge ap_clk); w++; end
    @(negedge ap_clk);
    arvalid = 1'b0; rready = 1'b1;
    got = 0; cyc = 0;
    while (cyc < 50) begin
      if (rvalid) begin
        if (got == 2) break;
        got++;
      end
      @(negedge ap_clk);
      cyc++;
    end
    chk("mid_reached_beat3", got, 2);
    chk("mid_beat3_data", rdata, {64{8'h12}});
    rst_n = 1'b0; rready = 1'b0;
    @(negedge ap_clk);
    chk("mid_rst_rvalid", rvalid, 1'b0);
    chk("mid_rst_rdata", rdata, '0);
    chk("mid_rst_rd_cnt", rd_burst_cnt, 32'd0);
    chk("mid_rst_err", err_wlast, 1'b0);
    @(negedge ap_clk);
    rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_arready", arready, 1'b1);
    chk("post_rst_rvalid", rvalid, 1'b0);
    axi_read(64'h1000, 3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      eb = 8'h10 + 8'(k);
      chk("post_rst_rdata", rd_buf[k], {64{eb}});
    end
    chk("post_rst_rd_cnt", rd_burst_cnt, 32'd1);

    // missing wlast on the final beat
    axi_write(64'h3000, 1, 8'h50, {64{1'b1}}, 2);
    chk("missing_wlast_err", err_wlast, 1'b1);
    chk("missing_wlast_wr_cnt", wr_burst_cnt, 32'd1);
    axi_read(64'h3000, 1, 1'b0);
    chk("rewrite_rd0", rd_buf[0], {64{8'h50}});
    chk("rewrite_rd1", rd_buf[1], {64{8'h51}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
